// File: rtl/button_debounce_pkg.sv
// Shared definitions for the pushbutton input path: auto-repeat state
// encoding and a helper to size timing parameters in milliseconds.
package button_debounce_pkg;

  localparam int CLOCK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic int ms_to_cycles(input int ms);
    return int'((longint'(CLOCK_HZ) * longint'(ms)) / 64'sd1000);
  endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin; both flops
// take RESET_VAL so the output is a known idle level straight out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Active-low pushbutton conditioner: synchronizer, consecutive-sample
// debouncer, and auto-repeat state machine producing one-cycle strobes.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press_stb,
  output logic release_stb,
  output logic repeat_stb
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

  logic              s;
  logic              db;
  logic [DCNT_W-1:0] dcnt;
  logic              accept;
  logic              press_evt;
  logic              release_evt;

  rep_state_t        state;
  rep_state_t        state_next;
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_next;
  logic              repeat_fire;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_n),
    .q    (s)
  );

  // An accepted transition is the last of DEBOUNCE_CYCLES disagreeing samples.
  assign accept      = (s != db) && (dcnt == DCNT_LAST);
  assign press_evt   = accept && !s;
  assign release_evt = accept && s;
  assign pressed     = ~db;

  always_ff @(posedge clk) begin
    if (reset) begin
      db          <= 1'b1;
      dcnt        <= '0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      if (s == db) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        db   <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      press_stb   <= press_evt;
      release_stb <= release_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rcnt       <= '0;
      repeat_stb <= 1'b0;
    end else begin
      state      <= state_next;
      rcnt       <= rcnt_next;
      repeat_stb <= repeat_fire;
    end
  end

  // A release always takes priority over a repeat timer expiring.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    if (release_evt) begin
      state_next = IDLE;
      rcnt_next  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press_evt && REPEAT_EN) begin
            state_next = HOLD;
            rcnt_next  = '0;
          end
        end
        HOLD: begin
          if (rcnt == DELAY_LAST) begin
            state_next = REPEAT;
            rcnt_next  = '0;
          end else begin
            rcnt_next = rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rcnt == PERIOD_LAST) begin
            rcnt_next = '0;
          end else begin
            rcnt_next = rcnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    repeat_fire = 1'b0;
    if (!release_evt) begin
      repeat_fire = ((state == HOLD)   && (rcnt == DELAY_LAST)) ||
                    ((state == REPEAT) && (rcnt == PERIOD_LAST));
    end
  end

endmodule
